// File: rtl/hazard_unit.sv
// hazard_unit
//   RAW-hazard and forwarding controller placed between decode and execute of
//   an in-order RISC-V pipeline. In-flight destination registers are tracked
//   in a shift-register scoreboard. Decode is held on unresolved
//   read-after-write hazards. The issued instruction is registered into EX
//   together with per-operand forwarding selects. A taken branch discards
//   decode for the branch cycle and the one after it. A saturating counter
//   counts the stall cycles.
//
//   Build option: define HAZARD_FWD_EN to enable forwarding. With it defined,
//   only a load-use stalls. Without it, any hazard stalls and the forwarding
//   selects are tied to 0.
//
// Parameters
//   DEPTH  scoreboard slots from EX (slot 0) to WB (slot DEPTH-1), 2..8
//   CNT_W  width of the stall-cycle counter
//
// Ports
//   clk          in   pipeline clock, rising edge
//   rst          in   asynchronous active-high reset
//   instr        in   instruction in decode (held by upstream while stall_o=1)
//   instr_valid  in   instr is real; 0 = bubble
//   br           in   taken branch/jump resolved this cycle (one-cycle pulse)
//   stall_o      out  combinational hold request for fetch/decode
//   hz_instr_o   out  registered instruction entering EX, 0 = bubble
//   fwd_a_o      out  registered rs1 source: 0 = regfile, k = slot k result
//   fwd_b_o      out  registered rs2 source, same encoding
//   stall_cnt_o  out  registered saturating count of stall cycles
//
// Handshake: decode offers instr qualified by instr_valid. The instruction is
// accepted on a rising edge where instr_valid=1, stall_o=0 and no flush is
// active. While stall_o=1, upstream must hold instr and instr_valid unchanged.
module hazard_unit #(
  parameter int DEPTH = 3,
  parameter int CNT_W = 16,
  localparam int FW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr,
  input  logic             instr_valid,
  input  logic             br,
  output logic             stall_o,
  output logic [31:0]      hz_instr_o,
  output logic [FW-1:0]    fwd_a_o,
  output logic [FW-1:0]    fwd_b_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  // Only slots 0..DEPTH-2 are stored. The slot DEPTH-1 occupant writes the
  // register file early enough for the next EX read, so it can never cause a
  // hazard and its entry has no observable effect.
  logic [DEPTH-2:0]      r_sb_valid;
  logic [DEPTH-2:0][4:0] r_sb_rd;
  logic                  r_flush_q;
  logic [31:0]           r_hz_instr;
  logic [FW-1:0]         r_fwd_a;
  logic [FW-1:0]         r_fwd_b;
  logic [CNT_W-1:0]      r_cnt;

  logic [6:0] w_op;
  logic [4:0] w_rd;
  logic [4:0] w_rs1;
  logic [4:0] w_rs2;
  logic       w_wr;
  logic       w_rd1;
  logic       w_rd2;
  logic       w_flush;
  logic       w_eval;
  logic       w_hit_a;
  logic       w_hit_b;
  logic       w_stall;
  logic       w_issue;

`ifdef HAZARD_FWD_EN
  logic          r_sb0_load;  // only slot 0 needs the load flag (load-use)
  logic          w_ld;
  logic          w_lu;
  logic [FW-1:0] w_sel_a;
  logic [FW-1:0] w_sel_b;
`endif

  assign w_op  = instr[6:0];
  assign w_rd  = instr[11:7];
  assign w_rs1 = instr[19:15];
  assign w_rs2 = instr[24:20];

  // Decode of register usage. x0 is neither a real destination nor a real
  // source, so both are filtered here.
  always_comb begin
    w_wr  = 1'b0;
    w_rd1 = 1'b0;
    w_rd2 = 1'b0;
    case (w_op)
      OP_LUI, OP_AUIPC, OP_JAL: w_wr = 1'b1;
      OP_JALR, OP_LOAD, OP_OPIMM: begin
        w_wr  = 1'b1;
        w_rd1 = 1'b1;
      end
      OP_OP: begin
        w_wr  = 1'b1;
        w_rd1 = 1'b1;
        w_rd2 = 1'b1;
      end
      OP_BRANCH, OP_STORE: begin
        w_rd1 = 1'b1;
        w_rd2 = 1'b1;
      end
      default: ;
    endcase
    w_wr  = w_wr  & (w_rd  != 5'd0);
    w_rd1 = w_rd1 & (w_rs1 != 5'd0);
    w_rd2 = w_rd2 & (w_rs2 != 5'd0);
  end

  // The flush covers the br cycle itself and the cycle after it.
  assign w_flush = br | r_flush_q;
  assign w_eval  = instr_valid & ~w_flush;

  // Hazard search. The scan runs from oldest to youngest so that the
  // youngest matching producer (lowest slot) overrides older ones.
  always_comb begin
    w_hit_a = 1'b0;
    w_hit_b = 1'b0;
`ifdef HAZARD_FWD_EN
    w_sel_a = '0;
    w_sel_b = '0;
`endif
    for (int k = DEPTH - 2; k >= 0; k--) begin
      if (w_eval && w_rd1 && r_sb_valid[k] && (r_sb_rd[k] == w_rs1)) begin
        w_hit_a = 1'b1;
`ifdef HAZARD_FWD_EN
        // Registered as k+1: by the consumer's EX cycle the producer has
        // advanced one slot.
        w_sel_a = FW'(k + 1);
`endif
      end
      if (w_eval && w_rd2 && r_sb_valid[k] && (r_sb_rd[k] == w_rs2)) begin
        w_hit_b = 1'b1;
`ifdef HAZARD_FWD_EN
        w_sel_b = FW'(k + 1);
`endif
      end
    end
  end

`ifdef HAZARD_FWD_EN
  assign w_ld = (w_op == OP_LOAD);
  // A load result is not available while the load is still in EX.
  assign w_lu = w_eval & r_sb_valid[0] & r_sb0_load &
                ((w_rd1 & (r_sb_rd[0] == w_rs1)) |
                 (w_rd2 & (r_sb_rd[0] == w_rs2)));
  assign w_stall = w_lu;
`else
  assign w_stall = w_hit_a | w_hit_b;
`endif

  assign w_issue = w_eval & ~w_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sb_valid <= '0;
      r_sb_rd    <= '0;
      r_flush_q  <= 1'b0;
      r_hz_instr <= '0;
      r_fwd_a    <= '0;
      r_fwd_b    <= '0;
      r_cnt      <= '0;
`ifdef HAZARD_FWD_EN
      r_sb0_load <= 1'b0;
`endif
    end else begin
      // Older slots always advance, including during stalls and flushes.
      for (int k = DEPTH - 2; k >= 1; k--) begin
        r_sb_valid[k] <= r_sb_valid[k-1];
        r_sb_rd[k]    <= r_sb_rd[k-1];
      end
      r_sb_valid[0] <= w_issue & w_wr;
      r_sb_rd[0]    <= w_rd;
      r_flush_q     <= br;
      r_hz_instr    <= w_issue ? instr : 32'd0;
`ifdef HAZARD_FWD_EN
      r_sb0_load    <= w_ld;
      r_fwd_a       <= w_issue ? w_sel_a : '0;
      r_fwd_b       <= w_issue ? w_sel_b : '0;
`else
      r_fwd_a       <= '0;
      r_fwd_b       <= '0;
`endif
      if (w_stall && (r_cnt != {CNT_W{1'b1}})) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign stall_o     = w_stall;
  assign hz_instr_o  = r_hz_instr;
  assign fwd_a_o     = r_fwd_a;
  assign fwd_b_o     = r_fwd_b;
  assign stall_cnt_o = r_cnt;

endmodule

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;

  localparam int DEPTH = 3;
  localparam int CNT_W = 4;  // narrow so the random run reaches saturation
  localparam int FW    = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};

`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  localparam logic [31:0] ADDI_X5  = 32'h00100293;
  localparam logic [31:0] ADD_X655 = 32'h00528333;
  localparam logic [31:0] LW_X5    = 32'h0000a283;
  localparam logic [31:0] ADDI_X0  = 32'h00100013;
  localparam logic [31:0] ADD_X600 = 32'h00000333;

  logic             clk;
  logic             rst;
  logic [31:0]      instr;
  logic             instr_valid;
  logic             br;
  logic             stall_o;
  logic [31:0]      hz_instr_o;
  logic [FW-1:0]    fwd_a_o;
  logic [FW-1:0]    fwd_b_o;
  logic [CNT_W-1:0] stall_cnt_o;

  hazard_unit #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst(rst),
    .instr(instr),
    .instr_valid(instr_valid),
    .br(br),
    .stall_o(stall_o),
    .hz_instr_o(hz_instr_o),
    .fwd_a_o(fwd_a_o),
    .fwd_b_o(fwd_b_o),
    .stall_cnt_o(stall_cnt_o)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // History of what was accepted at each past clock edge, youngest first.
  // Entry a was accepted a+1 edges ago; rd=0 means nothing was written.
  typedef struct packed {
    logic [4:0] rd;
    logic       ld;
  } ent_t;

  ent_t             hist[$];
  logic             m_flush_q;
  logic [CNT_W-1:0] m_cnt;
  logic [FW-1:0]    m_fa;
  logic [FW-1:0]    m_fb;
  logic [31:0]      exp_q[$];
  int               n_cmp;
  int               n_fail;

  function automatic bit is_writer(input logic [6:0] op);
    return op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_OPIMM, OP_OP};
  endfunction

  function automatic bit reads_rs1(input logic [6:0] op);
    return op inside {OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_OPIMM, OP_OP};
  endfunction

  function automatic bit reads_rs2(input logic [6:0] op);
    return op inside {OP_BRANCH, OP_STORE, OP_OP};
  endfunction

  // Age of the most recent producer of r whose result is not yet in the
  // register file (accepted at most DEPTH-1 edges ago), or -1.
  function automatic int producer_age(input logic [4:0] r);
    for (int a = 0; a < hist.size() && a < DEPTH - 1; a++) begin
      if (hist[a].rd == r) return a;
    end
    return -1;
  endfunction

  task automatic model_decode(input logic [31:0] ins, input logic v, input logic b,
                              output logic st, output logic [FW-1:0] fa,
                              output logic [FW-1:0] fb);
    int a1;
    int a2;
    st = 1'b0;
    fa = '0;
    fb = '0;
    if (v && !(b || m_flush_q)) begin
      a1 = (reads_rs1(ins[6:0]) && ins[19:15] != 5'd0) ? producer_age(ins[19:15]) : -1;
      a2 = (reads_rs2(ins[6:0]) && ins[24:20] != 5'd0) ? producer_age(ins[24:20]) : -1;
      if (FWD) begin
        st = ((a1 == 0) && hist[0].ld) || ((a2 == 0) && hist[0].ld);
        if (a1 >= 0) fa = FW'(a1 + 1);
        if (a2 >= 0) fb = FW'(a2 + 1);
      end else begin
        st = (a1 >= 0) || (a2 >= 0);
      end
    end
  endtask

  task automatic model_reset();
    hist.delete();
    exp_q.delete();
    m_flush_q = 1'b0;
    m_cnt     = '0;
    m_fa      = '0;
    m_fb      = '0;
  endtask

  // ---------------- driver ----------------
  // One clock cycle: drive decode inputs, check stall_o mid-cycle, advance
  // the model across the edge, check registered outputs just after it.
  // Returns the observed stall_o.
  task automatic step(input logic [31:0] ins, input logic v, input logic b,
                      output logic st_obs);
    logic          m_st;
    logic [FW-1:0] fa;
    logic [FW-1:0] fb;
    logic          issue;
    logic [31:0]   exp_hz;
    ent_t          e;
    instr       = ins;
    instr_valid = v;
    br          = b;
    @(negedge clk);
    model_decode(ins, v, b, m_st, fa, fb);
    st_obs = stall_o;
    n_cmp++;
    if (stall_o !== m_st) begin
      n_fail++;
      $display("FAIL stall_o: got %b expected %b (instr=%h v=%b br=%b)", stall_o, m_st, ins, v, b);
    end
    issue = !m_st && v && !(b || m_flush_q);
    exp_q.push_back(issue ? ins : 32'd0);
    m_fa = issue ? fa : '0;
    m_fb = issue ? fb : '0;
    e = '0;
    if (issue && is_writer(ins[6:0]) && ins[11:7] != 5'd0) begin
      e.rd = ins[11:7];
      e.ld = (ins[6:0] == OP_LOAD);
    end
    hist.push_front(e);
    if (hist.size() > DEPTH) void'(hist.pop_back());
    if (m_st && m_cnt != CMAX) m_cnt = m_cnt + CNT_W'(1);
    m_flush_q = b;
    @(posedge clk);
    #1;
    exp_hz = exp_q.pop_front();
    n_cmp++;
    if (hz_instr_o !== exp_hz) begin
      n_fail++;
      $display("FAIL hz_instr_o: got %h expected %h", hz_instr_o, exp_hz);
    end
    n_cmp++;
    if (fwd_a_o !== m_fa) begin
      n_fail++;
      $display("FAIL fwd_a_o: got %0d expected %0d", fwd_a_o, m_fa);
    end
    n_cmp++;
    if (fwd_b_o !== m_fb) begin
      n_fail++;
      $display("FAIL fwd_b_o: got %0d expected %0d", fwd_b_o, m_fb);
    end
    n_cmp++;
    if (stall_cnt_o !== m_cnt) begin
      n_fail++;
      $display("FAIL stall_cnt_o: got %0d expected %0d", stall_cnt_o, m_cnt);
    end
  endtask

  task automatic drain();
    logic st;
    repeat (DEPTH) step(32'd0, 1'b0, 1'b0, st);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst         = 1'b1;
    instr       = ADD_X655;
    instr_valid = 1'b1;
    br          = 1'b0;
    model_reset();
    #2;
    n_cmp++;
    if (stall_o !== 1'b0 || hz_instr_o !== 32'd0 || fwd_a_o !== '0 ||
        fwd_b_o !== '0 || stall_cnt_o !== '0) begin
      n_fail++;
      $display("FAIL reset_async: stall=%b hz=%h fa=%0d fb=%0d cnt=%0d expected all 0",
               stall_o, hz_instr_o, fwd_a_o, fwd_b_o, stall_cnt_o);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (hz_instr_o !== 32'd0 || stall_cnt_o !== '0) begin
      n_fail++;
      $display("FAIL reset_hold: hz=%h cnt=%0d expected 0", hz_instr_o, stall_cnt_o);
    end
    rst         = 1'b0;
    instr_valid = 1'b0;
  endtask

  // Producer then dependent consumer held in decode until accepted.
  task automatic test_pair(input string name, input logic [31:0] prod,
                           input logic [31:0] cons, input int exp_stalls,
                           input logic [FW-1:0] exp_fa, input logic [FW-1:0] exp_fb);
    logic st;
    int   n;
    drain();
    step(prod, 1'b1, 1'b0, st);
    n = 0;
    do begin
      step(cons, 1'b1, 1'b0, st);
      if (st) n++;
    end while (st && n < 10);
    n_cmp++;
    if (n != exp_stalls) begin
      n_fail++;
      $display("FAIL %s stall_cycles: got %0d expected %0d", name, n, exp_stalls);
    end
    n_cmp++;
    if (hz_instr_o !== cons || fwd_a_o !== exp_fa || fwd_b_o !== exp_fb) begin
      n_fail++;
      $display("FAIL %s issue: hz=%h fa=%0d fb=%0d expected hz=%h fa=%0d fb=%0d",
               name, hz_instr_o, fwd_a_o, fwd_b_o, cons, exp_fa, exp_fb);
    end
  endtask

  task automatic test_flush(input int nbr);
    logic st;
    int   bubbles;
    int   stalls;
    int   guard;
    drain();
    step(ADDI_X5, 1'b1, 1'b0, st);
    bubbles = 0;
    stalls  = 0;
    for (int i = 0; i < nbr; i++) begin
      step(ADD_X655, 1'b1, 1'b1, st);
      if (st) stalls++;
      if (hz_instr_o == 32'd0) bubbles++;
    end
    guard = 0;
    do begin
      step(ADD_X655, 1'b1, 1'b0, st);
      if (st) stalls++;
      if (hz_instr_o == 32'd0) bubbles++;
      guard++;
    end while (hz_instr_o != ADD_X655 && guard < 10);
    n_cmp++;
    if (bubbles != nbr + 1) begin
      n_fail++;
      $display("FAIL flush%0d bubbles: got %0d expected %0d", nbr, bubbles, nbr + 1);
    end
    n_cmp++;
    if (stalls != 0) begin
      n_fail++;
      $display("FAIL flush%0d stalls: got %0d expected 0", nbr, stalls);
    end
  endtask

  task automatic test_reset_mid_stall();
    logic st;
    drain();
    step(ADDI_X5, 1'b1, 1'b0, st);
    instr       = ADD_X655;
    instr_valid = 1'b1;
    br          = 1'b0;
    #2;
    n_cmp++;
    if (stall_o !== (FWD ? 1'b0 : 1'b1)) begin
      n_fail++;
      $display("FAIL rst_mid pre_stall: got %b expected %b", stall_o, !FWD);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (stall_o !== 1'b0 || hz_instr_o !== 32'd0 || fwd_a_o !== '0 ||
        fwd_b_o !== '0 || stall_cnt_o !== '0) begin
      n_fail++;
      $display("FAIL rst_mid async: stall=%b hz=%h fa=%0d fb=%0d cnt=%0d expected all 0",
               stall_o, hz_instr_o, fwd_a_o, fwd_b_o, stall_cnt_o);
    end
    instr_valid = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    rst = 1'b0;
    step(ADD_X655, 1'b1, 1'b0, st);
    n_cmp++;
    if (st !== 1'b0 || hz_instr_o !== ADD_X655) begin
      n_fail++;
      $display("FAIL rst_mid reissue: stall=%b hz=%h expected stall=0 hz=%h",
               st, hz_instr_o, ADD_X655);
    end
  endtask

  task automatic test_random(input int cycles);
    logic [6:0]  ops[10];
    logic [31:0] ins;
    logic        v;
    logic        b;
    logic        st;
    ops = '{OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD,
            OP_OPIMM, OP_OP, OP_BRANCH, OP_STORE, OP_FENCE};
    ins = 32'd0;
    v   = 1'b0;
    st  = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      // Upstream holds the stalled instruction.
      if (!st) begin
        ins        = $urandom;
        ins[6:0]   = ops[$urandom_range(0, 9)];
        ins[11:7]  = 5'($urandom_range(0, 3));
        ins[19:15] = 5'($urandom_range(0, 3));
        ins[24:20] = 5'($urandom_range(0, 3));
        v          = ($urandom_range(0, 7) != 0);
      end
      b = ($urandom_range(0, 9) == 0);
      step(ins, v, b, st);
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_pair("raw_alu", ADDI_X5, ADD_X655, FWD ? 0 : 2,
              FW'(FWD ? 1 : 0), FW'(FWD ? 1 : 0));
    test_pair("load_use", LW_X5, ADD_X655, FWD ? 1 : 2,
              FW'(FWD ? 2 : 0), FW'(FWD ? 2 : 0));
    test_pair("x0", ADDI_X0, ADD_X600, 0, FW'(0), FW'(0));
    test_flush(1);
    test_flush(2);
    test_reset_mid_stall();
    test_random(600);
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
